lc3_alu_seq: RTL and testbench
==============================

# lc3_alu_seq

Parametrised, multi-cycle successor to the LC-3 datapath ALU. It keeps the four LC-3 operations (ADD, AND, NOT, PASS A) and adds iterative shifts and an iterative multiply. A valid/ready handshake accepts operands, and the block returns a registered result with N/Z/P condition codes. It sits between the register-file read ports and the result tri-state bus, where it replaces the combinational ALU.

## Interface
Parameters:
- WIDTH, 16, datapath width in bits (≥4, power of two)
- SHW, $clog2(WIDTH), shift-amount width (derived; not overridden)

Ports (one clock; reset is synchronous and active-high):
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- A  input  WIDTH  operand A, sampled at accept
- B  input  WIDTH  operand B (shift amount = B[SHW-1:0]), sampled at accept
- ALUK  input  3  op: 0 ADD, 1 AND, 2 NOT A, 3 PASS A, 4 SHL, 5 SHR (logical), 6 SRA, 7 MUL
- in_valid  input  1  request present
- in_ready  output  1  high only in IDLE; accept = in_valid & in_ready at a rising edge
- out_to_tri  output  WIDTH  registered result, held until the next result
- nzp  output  3  {N,Z,P} of out_to_tri as signed, registered with it
- out_valid  output  1  one-cycle pulse marking a new result

## Operation
- State machine: IDLE, SHIFT, MUL, DONE.
- IDLE:
  - On accept, A, B and ALUK are latched; later input changes have no effect.
  - Ops 0–3, and ops 4–6 with amount 0: the result is computed and registered at the accept edge, and the state moves to DONE.
  - Ops 4–6 with amount n>0: the working register is loaded with A, the counter is loaded with n, and the state moves to SHIFT.
  - Op 7: the accumulator is cleared, the multiplicand is loaded with A, the multiplier with B, the counter with WIDTH, and the state moves to MUL.
- SHIFT: each cycle the working register shifts one bit and the counter decrements.
  - SHL fills with 0, SHR fills with 0, SRA fills with the MSB.
  - When the counter reaches 1, the final shift is written to out_to_tri and the state moves to DONE.
- MUL: each cycle, if multiplier[0] is set, the multiplicand is added to the accumulator. Then the multiplicand shifts left, the multiplier shifts right, and the counter decrements.
  - On the last iteration the accumulator sum is written to out_to_tri and the state moves to DONE.
  - The result is the low WIDTH bits of A*B, which is identical for signed and unsigned operands.
- DONE: out_valid=1 and in_ready=0; the next state is IDLE unconditionally.
- Arithmetic:
  - ADD wraps modulo 2^WIDTH; there is no carry or overflow output.
  - Shift amounts range from 0 to WIDTH-1.
- nzp:
  - N = out_to_tri[WIDTH-1].
  - Z = (out_to_tri==0).
  - P = neither N nor Z.
  - Exactly one bit is set after the first result.
- in_valid asserted outside IDLE is ignored. The requester must hold the request until in_ready.
- Reset: from any state, including mid-SHIFT or mid-MUL, the block goes to IDLE. out_to_tri=0, nzp=3'b000, out_valid=0, internal counters=0, and in_ready=1 from the cycle after the reset edge. An aborted operation produces no out_valid.
- Reset asserted together with in_valid: reset wins and nothing is accepted.

## Timing
- Latency L is counted from the accept edge E0 to the edge at which out_to_tri and nzp update. out_valid is high in the cycle following that edge.
  - Ops 0–3, and shifts by 0: L=1.
  - Shift by n>0: L=n+1.
  - MUL: L=WIDTH+1 (17 for WIDTH=16).
- out_to_tri and nzp change only at the edge entering DONE, and are stable otherwise.
- in_ready returns high in the cycle after DONE. Minimum initiation interval is 2 cycles (ops 0–3).
- Outputs are fully registered except in_ready, which is decoded from the state register.

## Test plan
- Reset, then ADD with A=1234, B=2345 -> out_to_tri=16'h0DFB, nzp=001, out_valid for exactly one cycle, 1 cycle after accept.
- A=16'h1234, B=16'hFFF0, ALUK=1/2/3, issued back-to-back -> 16'h1230 (nzp 001), 16'hEDCB (nzp 100), 16'h1234 (nzp 001). Each is accepted only when in_ready=1, with 2-cycle spacing.
- SRA with A=16'h8000, B=4 -> 16'hF800 after 5 cycles. SHR with the same operands -> 16'h0800. SHL with A=16'h0001, B=0 -> 16'h0001 at L=1. SHL with A=16'h0001, B=15 -> 16'h8000, nzp 100.
- MUL with A=16'h0012, B=16'h0034 -> 16'h03A8 at L=17. MUL with 16'hFFFF × 16'hFFFF -> 16'h0001. MUL with 0 × 16'h7FFF -> 16'h0000, nzp 010. Change A and B during MUL -> the result is unaffected, and in_valid held high during busy is not re-accepted.
- Assert reset for 1 cycle on the 5th MUL cycle -> no out_valid, out_to_tri=0, nzp=000, in_ready=1 the next cycle, and a new ADD 1+1 -> 16'h0002.
- Assert reset in the same cycle as in_valid -> no accept, and the held request is accepted on the first cycle after reset.

Source files
------------

// File: rtl/lc3_alu_seq.sv
// LC-3 ALU successor: single-cycle ADD/AND/NOT/PASS plus iterative shifts and multiply,
// behind a valid/ready handshake with a registered result and N/Z/P condition codes.
module lc3_alu_seq #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       ALUK,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_to_tri,
    output logic [2:0]       nzp,
    output logic             out_valid
);
    // Counter must hold WIDTH for the multiply iteration count
    localparam int unsigned CW = SHW + 1;

    typedef enum logic [1:0] {IDLE, SHIFT, MUL, DONE} state_t;

    state_t           state, state_nx;
    logic [2:0]       op;
    logic [WIDTH-1:0] work, mcand, mplier, acc;
    logic [CW-1:0]    cnt;

    logic [SHW-1:0]   amt;
    logic [WIDTH-1:0] alu_res, shift_res, mul_sum, result;
    logic             load_result;

    assign amt      = B[SHW-1:0];
    assign in_ready = (state == IDLE);
    assign mul_sum  = mplier[0] ? (acc + mcand) : acc;

    // Single-cycle ops; shifts by zero reduce to PASS A
    always_comb begin
        alu_res = A;
        case (ALUK)
            3'd0:    alu_res = A + B;
            3'd1:    alu_res = A & B;
            3'd2:    alu_res = ~A;
            default: alu_res = A;
        endcase
    end

    // One-bit step of the iterative shifter
    always_comb begin
        shift_res = work;
        case (op)
            3'd4:    shift_res = {work[WIDTH-2:0], 1'b0};
            3'd5:    shift_res = {1'b0, work[WIDTH-1:1]};
            3'd6:    shift_res = {work[WIDTH-1], work[WIDTH-1:1]};
            default: shift_res = work;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx    = state;
        load_result = 1'b0;
        result      = '0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    if (ALUK == 3'd7) begin
                        state_nx = MUL;
                    end else if (ALUK < 3'd4 || amt == '0) begin
                        load_result = 1'b1;
                        result      = alu_res;
                        state_nx    = DONE;
                    end else begin
                        state_nx = SHIFT;
                    end
                end
            end
            SHIFT: begin
                if (cnt == CW'(1)) begin
                    load_result = 1'b1;
                    result      = shift_res;
                    state_nx    = DONE;
                end
            end
            MUL: begin
                if (cnt == CW'(1)) begin
                    load_result = 1'b1;
                    result      = mul_sum;
                    state_nx    = DONE;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Datapath, counters and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            op         <= '0;
            work       <= '0;
            mcand      <= '0;
            mplier     <= '0;
            acc        <= '0;
            cnt        <= '0;
            out_to_tri <= '0;
            nzp        <= 3'b000;
            out_valid  <= 1'b0;
        end else begin
            out_valid <= load_result;
            if (load_result) begin
                out_to_tri <= result;
                nzp        <= {result[WIDTH-1], result == '0,
                               ~result[WIDTH-1] & (result != '0)};
            end
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op     <= ALUK;
                        work   <= A;
                        mcand  <= A;
                        mplier <= B;
                        acc    <= '0;
                        cnt    <= (ALUK == 3'd7) ? CW'(WIDTH) : CW'(amt);
                    end
                end
                SHIFT: begin
                    work <= shift_res;
                    cnt  <= cnt - CW'(1);
                end
                MUL: begin
                    acc    <= mul_sum;
                    mcand  <= {mcand[WIDTH-2:0], 1'b0};
                    mplier <= {1'b0, mplier[WIDTH-1:1]};
                    cnt    <= cnt - CW'(1);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_lc3_alu_seq.sv
// Directed bench for lc3_alu_seq: hand-computed results, latencies and reset behaviour.
module tb_lc3_alu_seq;
    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] A, B;
    logic [2:0]  ALUK;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] out_to_tri;
    logic [2:0]  nzp;
    logic        out_valid;

    int tests  = 0;
    int failed = 0;

    lc3_alu_seq #(.WIDTH(16)) dut (
        .clk(clk), .reset(reset), .A(A), .B(B), .ALUK(ALUK),
        .in_valid(in_valid), .in_ready(in_ready),
        .out_to_tri(out_to_tri), .nzp(nzp), .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one request, scramble operands after accept, and check result and latency
    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic [2:0] k, input logic [15:0] exp,
                          input logic [2:0] exp_nzp, input int exp_lat, input bit hold);
        int g;
        int lat;
        @(negedge clk);
        g = 0;
        while (!in_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        check({tag, "_ready"}, 32'(in_ready), 32'd1);
        A = a; B = b; ALUK = k; in_valid = 1'b1;
        @(posedge clk); #1;
        A = ~a; B = ~b;
        in_valid = hold;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_res"}, 32'(out_to_tri), 32'(exp));
        check({tag, "_nzp"}, 32'(nzp), 32'(exp_nzp));
        check({tag, "_busy"}, 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        check({tag, "_pulse"}, 32'(out_valid), 32'd0);
        check({tag, "_hold"}, 32'(out_to_tri), 32'(exp));
        in_valid = 1'b0;
    endtask

    initial begin
        int pulses;
        reset = 1'b1; A = '0; B = '0; ALUK = '0; in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check("rst_out", 32'(out_to_tri), 32'd0);
        check("rst_nzp", 32'(nzp), 32'd0);
        check("rst_vld", 32'(out_valid), 32'd0);
        check("rst_rdy", 32'(in_ready), 32'd1);

        run_op("add",   16'd1234,  16'd2345,  3'd0, 16'h0DFB, 3'b001, 1, 1'b0);
        run_op("and",   16'h1234,  16'hFFF0,  3'd1, 16'h1230, 3'b001, 1, 1'b1);
        run_op("not",   16'h1234,  16'hFFF0,  3'd2, 16'hEDCB, 3'b100, 1, 1'b1);
        run_op("pass",  16'h1234,  16'hFFF0,  3'd3, 16'h1234, 3'b001, 1, 1'b0);
        run_op("sra4",  16'h8000,  16'd4,     3'd6, 16'hF800, 3'b100, 5, 1'b0);
        run_op("shr4",  16'h8000,  16'd4,     3'd5, 16'h0800, 3'b001, 5, 1'b0);
        run_op("shl0",  16'h0001,  16'd0,     3'd4, 16'h0001, 3'b001, 1, 1'b0);
        run_op("shl15", 16'h0001,  16'd15,    3'd4, 16'h8000, 3'b100, 16, 1'b0);
        run_op("mul",   16'h0012,  16'h0034,  3'd7, 16'h03A8, 3'b001, 17, 1'b1);
        run_op("mul0",  16'h0000,  16'h7FFF,  3'd7, 16'h0000, 3'b010, 17, 1'b0);
        run_op("mulff", 16'hFFFF,  16'hFFFF,  3'd7, 16'h0001, 3'b001, 17, 1'b0);

        // Abort a multiply with reset on its 5th iteration cycle
        @(negedge clk);
        A = 16'h0012; B = 16'h0034; ALUK = 3'd7; in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        check("abort_vld", 32'(out_valid), 32'd0);
        check("abort_out", 32'(out_to_tri), 32'd0);
        check("abort_nzp", 32'(nzp), 32'd0);
        check("abort_rdy", 32'(in_ready), 32'd1);
        pulses = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (out_valid) pulses++;
        end
        check("abort_nopulse", 32'(pulses), 32'd0);
        run_op("add11", 16'd1, 16'd1, 3'd0, 16'h0002, 3'b001, 1, 1'b0);

        // Reset coincident with a request: nothing taken until reset drops
        @(negedge clk);
        A = 16'd5; B = 16'd6; ALUK = 3'd0; in_valid = 1'b1; reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        check("rstreq_vld", 32'(out_valid), 32'd0);
        check("rstreq_rdy", 32'(in_ready), 32'd1);
        @(posedge clk); #1 in_valid = 1'b0;
        check("rstreq_acc", 32'(out_valid), 32'd1);
        check("rstreq_res", 32'(out_to_tri), 32'h000B);
        check("rstreq_nzp", 32'(nzp), 32'b001);
        @(posedge clk); #1;
        check("rstreq_pulse", 32'(out_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
